branch_resolve_unit: RTL and testbench

Parametrised successor to the EX-stage branch condition logic. Evaluates the branch condition from the full source-register value for BEQZ/BNEZ/BLTZ/BGEZ. Keeps a direct-mapped branch history table (BHT) of 2-bit saturating counters, which fetch reads for prediction. Resolves each branch against its carried prediction and issues a registered mispredict/flush request to the fetch and decode stages.

---
 rtl/branch_pkg.sv | 23 ++
 rtl/sat_ctr2.sv | 28 ++
 rtl/branch_resolve_unit.sv | 132 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared opcode and branch-history counter constants for the branch resolve unit.
package branch_pkg;

    localparam logic [4:0] BEQZ = 5'b01100;
    localparam logic [4:0] BNEZ = 5'b01101;
    localparam logic [4:0] BGEZ = 5'b01110;
    localparam logic [4:0] BLTZ = 5'b01111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic is_branch(input logic [4:0] op);
        logic hit;
        case (op)
            BEQZ, BNEZ, BGEZ, BLTZ: hit = 1'b1;
            default:                hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/sat_ctr2.sv
// Next-state logic for one 2-bit saturating branch counter (SNT..ST).
module sat_ctr2
    import branch_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    // Step toward ST on taken, toward SNT otherwise, never wrapping.
    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur == ST) begin
                nxt = ST;
            end else begin
                nxt = cur + 2'd1;
            end
        end else begin
            if (cur == SNT) begin
                nxt = SNT;
            end else begin
                nxt = cur - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution with a direct-mapped 2-bit BHT and registered flush request.
// Optional statistics counters are enabled with the BRANCH_STATS_EN macro.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int         DATA_W   = 16,
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CTR_INIT = 2'b01
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  if_idx,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic [4:0]        ex_op,
    input  logic [DATA_W-1:0] ex_rs,
    input  logic [IDX_W-1:0]  ex_idx,
    input  logic              ex_pred_taken,
    output logic              bt,
    output logic              mispredict,
    output logic              br_resolved
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]       stat_branches,
    output logic [15:0]       stat_mispred
`endif
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] bht_r [DEPTH];
    logic       zero_s;
    logic       neg_s;
    logic       taken_s;
    logic       resolve_s;
    logic       wrong_s;
    logic [1:0] cur_s;
    logic [1:0] nxt_s;

    assign zero_s = (ex_rs == {DATA_W{1'b0}});
    assign neg_s  = ex_rs[DATA_W-1];

    // Fetch reads the stored counter directly: no bypass from a same-cycle update.
    assign if_pred_taken = bht_r[if_idx][1];

    // Branch condition from the full-width source register.
    always_comb begin
        taken_s = 1'b0;
        case (ex_op)
            BEQZ:    taken_s = zero_s;
            BNEZ:    taken_s = ~zero_s;
            BLTZ:    taken_s = neg_s;
            BGEZ:    taken_s = ~neg_s;
            default: taken_s = 1'b0;
        endcase
    end

    // An instruction seen while mispredict is high sits on the squashed path.
    assign resolve_s = ex_valid & ~ex_stall & is_branch(ex_op) & ~mispredict;
    assign wrong_s   = taken_s ^ ex_pred_taken;
    assign cur_s     = bht_r[ex_idx];

    sat_ctr2 u_sat_ctr2 (
        .cur   (cur_s),
        .taken (taken_s),
        .nxt   (nxt_s)
    );

    // Resolution outputs; bt holds between resolves, the pulses clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bt          <= 1'b0;
            mispredict  <= 1'b0;
            br_resolved <= 1'b0;
        end else if (resolve_s) begin
            bt          <= taken_s;
            mispredict  <= wrong_s;
            br_resolved <= 1'b1;
        end else begin
            mispredict  <= 1'b0;
            br_resolved <= 1'b0;
        end
    end

    // Branch history table: one counter written per resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bht_r[i] <= CTR_INIT;
            end
        end else if (resolve_s) begin
            bht_r[ex_idx] <= nxt_s;
        end else begin
            bht_r[ex_idx] <= cur_s;
        end
    end

`ifdef BRANCH_STATS_EN
    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    logic [15:0] stat_branches_r;
    logic [15:0] stat_mispred_r;

    // Saturating resolve and mispredict counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_r <= 16'h0000;
            stat_mispred_r  <= 16'h0000;
        end else if (resolve_s) begin
            if (stat_branches_r != STAT_MAX) begin
                stat_branches_r <= stat_branches_r + 16'd1;
            end else begin
                stat_branches_r <= stat_branches_r;
            end
            if (wrong_s && (stat_mispred_r != STAT_MAX)) begin
                stat_mispred_r <= stat_mispred_r + 16'd1;
            end else begin
                stat_mispred_r <= stat_mispred_r;
            end
        end else begin
            stat_branches_r <= stat_branches_r;
            stat_mispred_r  <= stat_mispred_r;
        end
    end

    assign stat_branches = stat_branches_r;
    assign stat_mispred  = stat_mispred_r;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed branches, monitor checks each resolve pulse.
module tb_branch_resolve_unit;
    import branch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  if_idx;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_stall;
    logic [4:0]  ex_op;
    logic [15:0] ex_rs;
    logic [3:0]  ex_idx;
    logic        ex_pred_taken;
    logic        bt;
    logic        mispredict;
    logic        br_resolved;
`ifdef BRANCH_STATS_EN
    logic [15:0] stat_branches;
    logic [15:0] stat_mispred;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic  ebt;
        logic  emp;
        string name;
    } exp_t;

    exp_t sb_q[$];

    branch_resolve_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_idx        (if_idx),
        .if_pred_taken (if_pred_taken),
        .ex_valid      (ex_valid),
        .ex_stall      (ex_stall),
        .ex_op         (ex_op),
        .ex_rs         (ex_rs),
        .ex_idx        (ex_idx),
        .ex_pred_taken (ex_pred_taken),
        .bt            (bt),
        .mispredict    (mispredict),
        .br_resolved   (br_resolved)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [15:0] rs, input logic [3:0] idx,
                         input logic pred);
        ex_op         = op;
        ex_rs         = rs;
        ex_idx        = idx;
        ex_pred_taken = pred;
        ex_valid      = 1'b1;
    endtask

    // One resolving branch followed by an idle cycle.
    task automatic issue(input string name, input logic [4:0] op, input logic [15:0] rs,
                         input logic [3:0] idx, input logic pred, input logic ebt, input logic emp);
        sb_q.push_back('{ebt: ebt, emp: emp, name: name});
        drive(op, rs, idx, pred);
        step();
        ex_valid = 1'b0;
        step();
    endtask

    task automatic chk_pred(input string name, input logic [3:0] idx, input logic exp);
        if_idx = idx;
        #1;
        chk(name, {15'd0, if_pred_taken}, {15'd0, exp});
    endtask

    // Monitor: every resolve pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (br_resolved) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_resolve", 16'd1, 16'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk({e.name, "_bt"}, {15'd0, bt}, {15'd0, e.ebt});
                    chk({e.name, "_mp"}, {15'd0, mispredict}, {15'd0, e.emp});
                end
            end else if (mispredict) begin
                chk("mispredict_without_resolve", 16'd1, 16'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        if_idx = 4'd0;
        ex_valid = 1'b0;
        ex_stall = 1'b0;
        ex_op = 5'd0;
        ex_rs = 16'h0000;
        ex_idx = 4'd0;
        ex_pred_taken = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        chk("rst_bt", {15'd0, bt}, 16'd0);
        chk("rst_mp", {15'd0, mispredict}, 16'd0);
        chk("rst_br", {15'd0, br_resolved}, 16'd0);
        chk_pred("rst_pred3", 4'd3, 1'b0);
`ifdef BRANCH_STATS_EN
        chk("rst_stat_br", stat_branches, 16'd0);
        chk("rst_stat_mp", stat_mispred, 16'd0);
`endif

        issue("beqz_idx3", BEQZ, 16'h0000, 4'd3, 1'b0, 1'b1, 1'b1);
        chk_pred("pred3_after", 4'd3, 1'b1);
        issue("bltz_neg", BLTZ, 16'h8000, 4'd7, 1'b1, 1'b1, 1'b0);
        chk_pred("pred7_after", 4'd7, 1'b1);
        issue("bgez_zero", BGEZ, 16'h0000, 4'd8, 1'b0, 1'b1, 1'b1);
        issue("bnez_one", BNEZ, 16'h0001, 4'd9, 1'b1, 1'b1, 1'b0);
        issue("bltz_pos", BLTZ, 16'h7FFF, 4'd9, 1'b0, 1'b0, 1'b0);
        issue("beqz_hibit", BEQZ, 16'h0100, 4'd9, 1'b1, 1'b0, 1'b1);
        issue("bgez_neg", BGEZ, 16'hFFFF, 4'd9, 1'b1, 1'b0, 1'b1);

        // Saturation at idx 5: 01 -> 10 -> 11 -> 11 -> 11, then down to 00.
        for (int i = 0; i < 4; i++) issue("sat_up", BEQZ, 16'h0000, 4'd5, 1'b1, 1'b1, 1'b0);
        chk_pred("sat_up_pred", 4'd5, 1'b1);
        issue("sat_dn1", BNEZ, 16'h0000, 4'd5, 1'b0, 1'b0, 1'b0);
        chk_pred("sat_top_held", 4'd5, 1'b1);
        for (int i = 0; i < 4; i++) issue("sat_dn", BNEZ, 16'h0000, 4'd5, 1'b0, 1'b0, 1'b0);
        chk_pred("sat_dn_pred", 4'd5, 1'b0);
        issue("sat_rise1", BEQZ, 16'h0000, 4'd5, 1'b0, 1'b1, 1'b1);
        chk_pred("sat_bottom_held", 4'd5, 1'b0);
        issue("sat_rise2", BEQZ, 16'h0000, 4'd5, 1'b1, 1'b1, 1'b0);
        chk_pred("sat_rise_pred", 4'd5, 1'b1);

        // Mispredict then a back-to-back BNEZ on the squashed path.
        sb_q.push_back('{ebt: 1'b1, emp: 1'b1, name: "squash_lead"});
        drive(BEQZ, 16'h0000, 4'd10, 1'b0);
        step();
        drive(BNEZ, 16'h0000, 4'd10, 1'b1);
        step();
        ex_valid = 1'b0;
        step();
        chk_pred("squash_bht", 4'd10, 1'b1);

        // Non-branch opcodes never resolve.
        drive(5'b01011, 16'h0000, 4'd4, 1'b1);
        step();
        drive(5'b10000, 16'h0000, 4'd4, 1'b1);
        step();
        ex_valid = 1'b0;
        step();
        chk_pred("nonbranch_bht", 4'd4, 1'b0);

        // Stall holds the branch; it resolves once on release.
        ex_stall = 1'b1;
        drive(BEQZ, 16'h0000, 4'd11, 1'b1);
        step();
        step();
        step();
        chk_pred("stall_bht", 4'd11, 1'b0);
        chk("stall_br", {15'd0, br_resolved}, 16'd0);
        sb_q.push_back('{ebt: 1'b1, emp: 1'b0, name: "stall_release"});
        ex_stall = 1'b0;
        step();
        ex_valid = 1'b0;
        step();
        chk_pred("stall_once_bht", 4'd11, 1'b1);

        // Reset mid-stream: outputs clear at once, counters return to WNT.
        drive(BEQZ, 16'h0000, 4'd3, 1'b0);
        step();
        chk("pre_rst_bt", {15'd0, bt}, 16'd1);
        chk("pre_rst_mp", {15'd0, mispredict}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_bt", {15'd0, bt}, 16'd0);
        chk("async_rst_mp", {15'd0, mispredict}, 16'd0);
        chk("async_rst_br", {15'd0, br_resolved}, 16'd0);
        drive(BEQZ, 16'h0000, 4'd12, 1'b1);
        step();
        step();
        ex_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk_pred("rst_pred3_cleared", 4'd3, 1'b0);
        chk_pred("rst_pred5_cleared", 4'd5, 1'b0);
        chk_pred("rst_pred11_cleared", 4'd11, 1'b0);
        chk_pred("rst_discard12", 4'd12, 1'b0);
`ifdef BRANCH_STATS_EN
        chk("rst2_stat_br", stat_branches, 16'd0);
        chk("rst2_stat_mp", stat_mispred, 16'd0);
`endif

        issue("post_bnez", BNEZ, 16'h0001, 4'd1, 1'b1, 1'b1, 1'b0);
        issue("post_bltz", BLTZ, 16'h7FFF, 4'd1, 1'b0, 1'b0, 1'b0);
        issue("post_beqz", BEQZ, 16'h0005, 4'd1, 1'b1, 1'b0, 1'b1);
`ifdef BRANCH_STATS_EN
        chk("stat_branches", stat_branches, 16'd3);
        chk("stat_mispred", stat_mispred, 16'd1);
`endif

        step();
        chk("scoreboard_drained", 16'(sb_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
